// File: rtl/instruction_encoder.sv
// ----------------------------------------------------------------------------
// instruction_encoder : packs RV32 fields and a signed immediate into an
// instruction word through a two-stage valid/ready pipeline.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package types;
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } inst_format_t;
endpackage

module instruction_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  types::inst_format_t  in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  import types::*;

  logic                 s1_valid_q;
  inst_format_t         s1_fmt_q;
  logic [6:0]           s1_opcode_q;
  logic [4:0]           s1_rd_q;
  logic [4:0]           s1_rs1_q;
  logic [4:0]           s1_rs2_q;
  logic [2:0]           s1_funct3_q;
  logic [6:0]           s1_funct7_q;
  logic [31:0]          s1_imm_q;
  logic                 s1_err_q;

  logic                 s2_valid_q;
  logic [31:0]          s2_inst_q;
  logic                 s2_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic                 s2_adv;
  logic                 in_fire;
  logic                 imm_err_d;
  logic [31:0]          inst_d;
  logic [ERR_CNT_W-1:0] err_cnt_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // A range check is a sign-extension check: the bits above the field must all match.
  always_comb begin
    imm_err_d = 1'b0;
    case (in_fmt)
      I_TYPE, S_TYPE: imm_err_d = (in_imm[31:11] != '0) && (in_imm[31:11] != '1);
      B_TYPE:         imm_err_d = ((in_imm[31:12] != '0) && (in_imm[31:12] != '1)) || in_imm[0];
      J_TYPE:         imm_err_d = ((in_imm[31:20] != '0) && (in_imm[31:20] != '1)) || in_imm[0];
      U_TYPE:         imm_err_d = (in_imm[11:0] != 12'd0);
      default:        imm_err_d = 1'b0;
    endcase
  end

  always_comb begin
    inst_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
    case (s1_fmt_q)
      I_TYPE: inst_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
      S_TYPE: inst_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                        s1_imm_q[4:0], s1_opcode_q};
      B_TYPE: inst_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                        s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
      U_TYPE: inst_d = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
      J_TYPE: inst_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                        s1_rd_q, s1_opcode_q};
      default: ;
    endcase
    if (s1_err_q) inst_d = '0;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_fmt_q    <= R_TYPE;
      s1_opcode_q <= '0;
      s1_rd_q     <= '0;
      s1_rs1_q    <= '0;
      s1_rs2_q    <= '0;
      s1_funct3_q <= '0;
      s1_funct7_q <= '0;
      s1_imm_q    <= '0;
      s1_err_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= '0;
      s2_err_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_fmt_q    <= in_fmt;
        s1_opcode_q <= in_opcode;
        s1_rd_q     <= in_rd;
        s1_rs1_q    <= in_rs1;
        s1_rs2_q    <= in_rs2;
        s1_funct3_q <= in_funct3;
        s1_funct7_q <= in_funct7;
        s1_imm_q    <= in_imm;
        s1_err_q    <= imm_err_d;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        // Data only moves with a real word so the output holds its last value when idle.
        if (s1_valid_q) begin
          s2_inst_q <= inst_d;
          s2_err_q  <= s1_err_q;
        end
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_inst  = s2_inst_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_encoder.sv
// ----------------------------------------------------------------------------
// tb_instruction_encoder : table, directed and random checks of the encoder
// against a behavioural model and scoreboard.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_instruction_encoder;
  import types::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready, in_ready2;
  inst_format_t in_fmt;
  logic [6:0]   in_opcode, in_funct7;
  logic [4:0]   in_rd, in_rs1, in_rs2;
  logic [2:0]   in_funct3;
  logic [31:0]  in_imm;
  logic         out_valid, out_valid2;
  logic         out_ready;
  logic [31:0]  out_inst, out_inst2;
  logic         out_err, out_err2;
  logic [15:0]  err_count;
  logic [1:0]   err_count2;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err(out_err), .err_count(err_count)
  );

  instruction_encoder #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_err(out_err2), .err_count(err_count2)
  );

  typedef struct {
    inst_format_t fmt;
    logic [6:0]   op;
    logic [4:0]   rd, rs1, rs2;
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [31:0]  imm;
    logic [31:0]  exp_inst;
    logic         exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mcnt = 0;
  exp_t q[$];
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: legality from signed integer ranges, packing from shifts and masks.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int          s;
    logic [31:0] u, op, rd, rs1, rs2, f3, f7;
    s = $signed(v.imm);
    u = v.imm;
    op = 32'(v.op); rd = 32'(v.rd); rs1 = 32'(v.rs1);
    rs2 = 32'(v.rs2); f3 = 32'(v.f3); f7 = 32'(v.f7);
    e.err = 1'b0;
    case (v.fmt)
      I_TYPE, S_TYPE: e.err = (s < -2048) || (s > 2047);
      B_TYPE:         e.err = (s < -4096) || (s > 4094) || (s % 2 != 0);
      J_TYPE:         e.err = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      U_TYPE:         e.err = (u % 4096) != 0;
      default:        e.err = 1'b0;
    endcase
    case (v.fmt)
      I_TYPE: e.inst = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((u & 32'hFFF) << 20);
      S_TYPE: e.inst = op | ((u & 32'h1F) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                       | (((u >> 5) & 32'h7F) << 25);
      B_TYPE: e.inst = op | (((u >> 11) & 32'h1) << 7) | (((u >> 1) & 32'hF) << 8)
                       | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                       | (((u >> 5) & 32'h3F) << 25) | (((u >> 12) & 32'h1) << 31);
      U_TYPE: e.inst = op | (rd << 7) | (u & 32'hFFFFF000);
      J_TYPE: e.inst = op | (rd << 7) | (((u >> 12) & 32'hFF) << 12)
                       | (((u >> 11) & 32'h1) << 20) | (((u >> 1) & 32'h3FF) << 21)
                       | (((u >> 20) & 32'h1) << 31);
      default: e.inst = op | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
    endcase
    if (e.err) e.inst = 32'h0;
    return e;
  endfunction

  function automatic vec_t mk(input inst_format_t f, input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] ei, input logic ee);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp_inst = ei; v.exp_err = ee;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   bnd[14] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                      -1048577, -1048576, 1048574, 1048575, 1048576};
    v.fmt = inst_format_t'(3'($urandom_range(0, 7)));
    v.op = 7'($urandom); v.rd = 5'($urandom); v.rs1 = 5'($urandom);
    v.rs2 = 5'($urandom); v.f3 = 3'($urandom); v.f7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0:       v.imm = $urandom;
      1:       v.imm = 32'($urandom_range(0, 8192)) - 32'd4096;
      2:       v.imm = 32'(bnd[$urandom_range(0, 13)]);
      default: v.imm = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 7) == 0);
    endcase
    v.exp_inst = 32'h0; v.exp_err = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1;
    in_rs2 = v.rs2; in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  // Entered and left at posedge+1; one cycle per accepted word when in_ready stays high.
  task automatic send(input vec_t v, input exp_t e);
    int n = 0;
    bit done = 1'b0;
    drive(v);
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        q.push_back(e);
        done = 1'b1;
      end else begin
        n++;
        if (n > 200) begin
          checks++; failures++;
          $display("FAIL send_timeout: in_ready stuck low, got 0 required 1");
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_tbl(input vec_t v);
    exp_t e;
    e.inst = v.exp_inst; e.err = v.exp_err;
    send(v, e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, 32'(q.size()), 32'd0);
    @(negedge clk);
    chk({name, "_no_extra"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: output order/content, stall stability and error counters.
  initial begin : monitor
    exp_t        e;
    bit          prev_stall;
    logic [31:0] prev_inst;
    logic        prev_err;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        mcnt = 0;
        prev_stall = 1'b0;
      end else begin
        chk("err_count", 32'(err_count), 32'((mcnt > 65535) ? 65535 : mcnt));
        chk("err_count_sat", 32'(err_count2), 32'((mcnt > 3) ? 3 : mcnt));
        if (prev_stall) begin
          chk("stall_inst_stable", out_inst, prev_inst);
          chk("stall_err_stable", 32'(out_err), 32'(prev_err));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word: got 0x%08h required no word", out_inst);
          end else begin
            e = q.pop_front();
            chk("out_inst", out_inst, e.inst);
            chk("out_err", 32'(out_err), 32'(e.err));
            chk("out_inst_sat_dut", out_inst2, e.inst);
            if (e.err) mcnt++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_inst  = out_inst;
        prev_err   = out_err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t v;
    vec_t bp[4];
    int   lat, acc, t0;
    bit   rand_done;

    tbl[0]  = mk(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        32'h00500093, 1'b0);
    tbl[1]  = mk(S_TYPE, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,        32'h0020A423, 1'b0);
    tbl[2]  = mk(B_TYPE, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    tbl[3]  = mk(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0);
    tbl[4]  = mk(J_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h001000EF, 1'b0);
    tbl[5]  = mk(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     32'h00000000, 1'b1);
    tbl[6]  = mk(B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd6,        32'h00208363, 1'b0);
    tbl[7]  = mk(B_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,        32'h00000000, 1'b1);
    tbl[8]  = mk(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001001, 32'h00000000, 1'b1);
    tbl[9]  = mk(R_TYPE, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0);
    tbl[10] = mk(J_TYPE, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0);
    tbl[11] = mk(J_TYPE, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000FFFFE, 32'h7FFFF06F, 1'b0);
    tbl[12] = mk(I_TYPE, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000113, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(tbl[0]);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Single word: out_valid must appear two cycles after the handshake cycle.
    send_tbl(tbl[0]);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    @(posedge clk); #1;

    // Back-to-back table stream, one word per cycle.
    t0 = cyc;
    for (int i = 1; i < 13; i++) send_tbl(tbl[i]);
    chk("stream_cycles", 32'(cyc - t0), 32'd12);
    drain("table");
    chk("table_err_count", 32'(err_count), 32'd3);

    // Backpressure: five cycles of stall with input offered.
    for (int i = 0; i < 4; i++) begin
      bp[i] = rand_vec();
      bp[i].fmt = R_TYPE;
    end
    out_ready = 1'b0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(bp[acc]);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(bp[acc]));
        acc++;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_inst", out_inst, model(bp[0]).inst);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(bp[2], model(bp[2]));
    send(bp[3], model(bp[3]));
    drain("bp");

    // Reset with both stages full.
    out_ready = 1'b0;
    send_tbl(tbl[5]);
    send_tbl(tbl[7]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_tbl(tbl[3]);
    drain("post_rst");

    // Saturation of the narrow counter.
    for (int i = 0; i < 5; i++) begin
      v = tbl[5];
      v.imm = 32'(4096 + i);
      send(v, model(v));
    end
    drain("sat");
    chk("sat_count_narrow", 32'(err_count2), 32'd3);
    chk("sat_count_wide", 32'(err_count), 32'd5);

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          v = rand_vec();
          send(v, model(v));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Inverse of the core's immediate decode path. Packs instruction fields and a 32-bit signed immediate into a 32-bit RV32 instruction word.
- Range- and alignment-checks the immediate for its format.
- Used by the self-test program generator and debug instruction injector to feed the fetch/decode path.
- Two-stage valid/ready pipeline with full throughput and backpressure, plus a saturating error counter.

Parameters:
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request this cycle
in_fmt  input  types::inst_format_t  instruction format (I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE; any other value = R layout)
in_opcode  input  7  opcode, placed at inst[6:0]
in_rd  input  5  rd, placed at inst[11:7] (I/U/J/R)
in_rs1  input  5  rs1, inst[19:15] (I/S/B/R)
in_rs2  input  5  rs2, inst[24:20] (S/B/R)
in_funct3  input  3  inst[14:12] (I/S/B/R)
in_funct7  input  7  inst[31:25] (R only)
in_imm  input  32  full signed immediate value, byte offset for B/J
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_inst  output  32  encoded instruction
out_err  output  1  immediate illegal for format; qualified by out_valid
err_count  output  ERR_CNT_W  number of errored words accepted at output, saturating

Behaviour:
- Reset (rst=1 at clock edge) has priority over all other activity.
  - Clears both stage valids and err_count.
  - Outputs after reset: out_valid=0, out_inst=0, out_err=0, err_count=0.
  - In-flight words are discarded, with no partial output.
- Stage 1 captures inputs on in_valid&&in_ready.
  - Registers the fields and computes the error flag.
- Stage 2 packs the instruction word into the output register. Latency from input handshake to out_valid is 2 cycles when there is no stall.
- Stall rules:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when s2 advances.
  - in_ready = !s1_valid || s2 advances. in_ready is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Throughput: 1 word/cycle when out_ready stays high.
- Stability: while out_valid && !out_ready, out_inst and out_err must hold stable.
- Packing (inst bits):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - R: [31:25]=funct7; in_imm ignored.
  - Unused fields for a format are not placed.
- Legality (err=1 when violated):
  - I/S: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]=0.
  - J: -1048576 <= imm <= 1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: never errs.
- On err: out_inst=32'h0000_0000 and out_err=1.
- err_count increments by 1 on each out_valid&&out_ready&&out_err. It saturates at all-ones and never wraps.
- Simultaneous s1 fill and s2 drain in the same cycle: both occur, with no bubble.

Test Plan:
- Single I-type, fmt=I, opcode=0x13, rd=1, rs1=0, f3=0, imm=5, out_ready=1 -> out_inst=0x00500093, out_err=0, out_valid exactly 2 cycles after handshake.
- Back-to-back stream at 1/cycle:
  - S: opcode 0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
  - B: opcode 0x63, imm=-4 -> 0xFE000EE3.
  - U: opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - J: opcode 0x6F, rd=1, imm=2048 -> 0x001000EF.
  - Check in order, no bubbles.
- Errors:
  - I imm=2048 -> err.
  - B imm=6 -> no err; B imm=3 -> err.
  - U imm=0x00001001 -> err.
  - Each errored word has out_inst=0. err_count=3 after all errored words are accepted.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1.
  - Exactly 2 words are accepted, then in_ready=0.
  - out_inst stays stable.
  - After release, all words emerge in order with none lost or duplicated.
- Reset mid-operation: assert rst with both stages full -> next cycle out_valid=0, err_count=0, in_ready=1; the first word after reset encodes correctly.
- Saturation: with ERR_CNT_W=2, send 5 errored words -> err_count stays at 3.
